// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator with a runtime ratio and shift, round-half-up gain
// compensation, per-lane saturation and a one-entry valid/ready output register.
module cic_decimator_mc #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int STAGES    = 3,
    parameter int MAX_DECIM = 64,
    parameter int CHANNELS  = 2,
    localparam int W  = IN_WIDTH + STAGES * $clog2(MAX_DECIM),
    localparam int CW = $clog2(MAX_DECIM) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [CW-1:0]                 cfg_decim,
    input  logic [5:0]                    cfg_shift,
    input  logic                          in_valid,
    input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]           sat_flag,
    output logic                          overrun
);
    localparam int WUW = $clog2(STAGES + 1);
    localparam logic [WUW-1:0] WARM_DONE = WUW'(STAGES);
    localparam logic [5:0] SHIFT_MAX = (W - 1 > 63) ? 6'd63 : 6'(W - 1);
    localparam logic signed [W:0] SAT_MAX = {{(W-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W:0] SAT_MIN = {{(W-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef logic signed [W-1:0] acc_t;

    function automatic logic [CW-1:0] clamp_decim(input logic [CW-1:0] r);
        if (r < CW'(2)) return CW'(2);
        if (r > CW'(MAX_DECIM)) return CW'(MAX_DECIM);
        return r;
    endfunction

    function automatic logic [5:0] clamp_shift(input logic [5:0] s);
        return (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

    acc_t integ_q [CHANNELS][STAGES];
    acc_t integ_d [CHANNELS][STAGES];
    acc_t samp_q  [CHANNELS];
    acc_t samp_d  [CHANNELS];
    acc_t dly_q   [CHANNELS][STAGES];
    acc_t dly_d   [CHANNELS][STAGES];
    acc_t comb_q  [CHANNELS][STAGES];
    acc_t comb_d  [CHANNELS][STAGES];
    acc_t stage_in [CHANNELS][STAGES];
    acc_t x;

    logic [STAGES-1:0] comb_v_q, comb_v_d, stage_v;
    logic              stb_q, stb_d;
    logic              samp_v_q, samp_v_d;
    logic [CW-1:0]     decim_q, decim_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [5:0]        shift_q, shift_d;
    logic [WUW-1:0]    warm_q, warm_d;
    logic              present;

    logic                          out_valid_q, out_valid_d;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CHANNELS-1:0]           sat_q, sat_d;
    logic                          overrun_q, overrun_d;

    logic signed [W:0]             ext, rnd, sum, shf;
    logic [CHANNELS*OUT_WIDTH-1:0] scaled;
    logic [CHANNELS-1:0]           sat_lane;

    // Integrator chain uses each stage's freshly updated value, so the last stage
    // holds the full N-th order running sum including the current sample.
    always_comb begin
        integ_d = integ_q;
        cnt_d   = cnt_q;
        stb_d   = 1'b0;
        decim_d = decim_q;
        shift_d = shift_q;
        x       = '0;
        if (cfg_load) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < STAGES; s++)
                    integ_d[c][s] = '0;
            cnt_d   = '0;
            decim_d = clamp_decim(cfg_decim);
            shift_d = clamp_shift(cfg_shift);
        end else if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x = {{(W-IN_WIDTH){in_data[c*IN_WIDTH+IN_WIDTH-1]}}, in_data[c*IN_WIDTH +: IN_WIDTH]};
                for (int s = 0; s < STAGES; s++) begin
                    integ_d[c][s] = integ_q[c][s] + x;
                    x = integ_d[c][s];
                end
            end
            if (cnt_q == decim_q - CW'(1)) begin
                cnt_d = '0;
                stb_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Decimated-rate comb pipeline: one stage per clock behind the strobe.
    always_comb begin
        samp_v_d = 1'b0;
        samp_d   = samp_q;
        comb_v_d = '0;
        comb_d   = comb_q;
        dly_d    = dly_q;
        stage_v[0] = samp_v_q;
        for (int s = 1; s < STAGES; s++) stage_v[s] = comb_v_q[s-1];
        for (int c = 0; c < CHANNELS; c++) begin
            stage_in[c][0] = samp_q[c];
            for (int s = 1; s < STAGES; s++) stage_in[c][s] = comb_q[c][s-1];
        end
        if (cfg_load) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < STAGES; s++)
                    dly_d[c][s] = '0;
        end else begin
            samp_v_d = stb_q;
            if (stb_q)
                for (int c = 0; c < CHANNELS; c++) samp_d[c] = integ_q[c][STAGES-1];
            for (int s = 0; s < STAGES; s++) begin
                comb_v_d[s] = stage_v[s];
                if (stage_v[s]) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        comb_d[c][s] = stage_in[c][s] - dly_q[c][s];
                        dly_d[c][s]  = stage_in[c][s];
                    end
                end
            end
        end
    end

    // One guard bit keeps the rounding add from overflowing near full scale.
    always_comb begin
        rnd      = '0;
        ext      = '0;
        sum      = '0;
        shf      = '0;
        scaled   = '0;
        sat_lane = '0;
        if (shift_q != 6'd0) rnd = (W+1)'(1) << (shift_q - 6'd1);
        for (int c = 0; c < CHANNELS; c++) begin
            ext = {comb_q[c][STAGES-1][W-1], comb_q[c][STAGES-1]};
            sum = ext + rnd;
            shf = sum >>> shift_q;
            if (shf > SAT_MAX) begin
                sat_lane[c] = 1'b1;
                scaled[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shf < SAT_MIN) begin
                sat_lane[c] = 1'b1;
                scaled[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                scaled[c*OUT_WIDTH +: OUT_WIDTH] = shf[OUT_WIDTH-1:0];
            end
        end
    end

    // Handshake: a result transfers on any cycle where out_valid && out_ready; a new
    // result always loads, and overwriting an unaccepted one raises overrun.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        overrun_d   = overrun_q;
        warm_d      = warm_q;
        present     = 1'b0;
        if (cfg_load) begin
            warm_d    = '0;
            sat_d     = '0;
            overrun_d = 1'b0;
        end else if (comb_v_q[STAGES-1]) begin
            if (warm_q == WARM_DONE) present = 1'b1;
            else warm_d = warm_q + WUW'(1);
        end
        if (present) begin
            out_valid_d = 1'b1;
            out_data_d  = scaled;
            sat_d       = sat_q | sat_lane;
            if (out_valid_q && !out_ready) overrun_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                samp_q[c] <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    integ_q[c][s] <= '0;
                    dly_q[c][s]   <= '0;
                    comb_q[c][s]  <= '0;
                end
            end
            comb_v_q    <= '0;
            stb_q       <= 1'b0;
            samp_v_q    <= 1'b0;
            cnt_q       <= '0;
            warm_q      <= '0;
            decim_q     <= clamp_decim(cfg_decim);
            shift_q     <= clamp_shift(cfg_shift);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            samp_q      <= samp_d;
            dly_q       <= dly_d;
            comb_q      <= comb_d;
            comb_v_q    <= comb_v_d;
            stb_q       <= stb_d;
            samp_v_q    <= samp_v_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            decim_q     <= decim_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed bench for cic_decimator_mc (N=3, 2 lanes, 16-bit): expected results are
// queued per decimated block and checked by a negedge monitor on each transfer.
module tb_cic_decimator_mc;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_load = 1'b0;
    logic [6:0]  cfg_decim = 7'd8;
    logic [5:0]  cfg_shift = 6'd9;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  sat_flag;
    logic        overrun;

    always #5 clk = ~clk;

    cic_decimator_mc #(
        .IN_WIDTH(16), .OUT_WIDTH(16), .STAGES(N), .MAX_DECIM(64), .CHANNELS(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_decim(cfg_decim),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .overrun(overrun)
    );

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int r_cur = 8;
    int blk_cnt = 0;
    bit drop_next = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [31:0] pk(input int l0, input int l1);
        return {16'(l1), 16'(l0)};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_unexpected: got %0h expected none", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset(input logic [6:0] d, input logic [5:0] s, input int r);
        cfg_decim = d;
        cfg_shift = s;
        in_valid  = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        r_cur = r;
        blk_cnt = 0;
        drop_next = 1'b0;
    endtask

    // Junk on in_valid/in_data during the load must be ignored; the later cfg
    // changes must have no effect until the next load.
    task automatic do_cfg(input logic [6:0] d, input logic [5:0] s, input int r);
        cfg_decim = d;
        cfg_shift = s;
        cfg_load  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        cfg_decim = 7'd3;
        cfg_shift = 6'd1;
        r_cur = r;
        blk_cnt = 0;
    endtask

    task automatic run_block(input int v0, input int v1, input int e0, input int e1, input bit gap);
        for (int i = 0; i < r_cur; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = pk(v0, v1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (blk_cnt >= N && !drop_next) exp_q.push_back(pk(e0, e1));
        drop_next = 1'b0;
        blk_cnt++;
    endtask

    task automatic latency_check(input string name);
        int first;
        int nv;
        first = 0;
        nv = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                nv++;
                if (first == 0) first = k;
            end
        end
        check(name, first, N + 2);
        check({name, "_count"}, nv, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state and latency with continuous input; 100 / -100 at unity gain.
        do_reset(7'd8, 6'd9, 8);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_overrun", overrun, 0);
        for (int b = 0; b < 4; b++) run_block(100, -100, 100, -100, 1'b0);
        latency_check("latency_cont");
        for (int b = 0; b < 2; b++) run_block(100, -100, 100, -100, 1'b0);
        idle(8);
        check("dc_sat", sat_flag, 0);
        check("dc_overrun", overrun, 0);

        // Gapped input gives the same latency and data.
        do_reset(7'd8, 6'd9, 8);
        for (int b = 0; b < 4; b++) run_block(100, -100, 100, -100, 1'b1);
        latency_check("latency_gap");

        // Backpressure: step to zero, two transitional results, the first overwritten.
        out_ready = 1'b0;
        drop_next = 1'b1;
        run_block(0, 0, 77, -77, 1'b0);
        run_block(0, 0, 11, -11, 1'b0);
        idle(6);
        check("bp_overrun", overrun, 1);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, pk(11, -11));
        out_ready = 1'b1;
        idle(2);

        // cfg_load clears overrun; acceptance coincident with a new result.
        do_cfg(7'd8, 6'd9, 8);
        check("cfg_overrun_clr", overrun, 0);
        for (int b = 0; b < 4; b++) run_block(100, -100, 100, -100, 1'b0);
        idle(6);
        out_ready = 1'b0;
        run_block(100, -100, 100, -100, 1'b0);
        run_block(100, -100, 100, -100, 1'b0);
        idle(4);
        out_ready = 1'b1;
        idle(3);
        check("coincident_no_overrun", overrun, 0);
        check("coincident_both_seen", exp_q.size(), 0);

        // Pending result survives cfg_load; R=1 clamps to 2; round half up at shift 4.
        out_ready = 1'b0;
        run_block(100, -100, 100, -100, 1'b0);
        idle(6);
        do_cfg(7'd1, 6'd4, 2);
        check("cfg_pending_valid", out_valid, 1);
        check("cfg_pending_data", out_data, pk(100, -100));
        out_ready = 1'b1;
        idle(2);
        for (int b = 0; b < 6; b++) run_block(1, -1, 1, 0, 1'b0);
        idle(8);

        // Saturation on lane 0, sticky through the return to zero; lane 1 in range.
        do_cfg(7'd8, 6'd0, 8);
        check("sat_clr_a", sat_flag, 0);
        for (int b = 0; b < 5; b++) run_block(32767, 5, 32767, 2560, 1'b0);
        run_block(0, 0, 32767, 1960, 1'b0);
        run_block(0, 0, 32767, 280, 1'b0);
        run_block(0, 0, 0, 0, 1'b0);
        idle(8);
        check("sat_sticky_lane0", sat_flag, 2'b01);
        do_cfg(7'd8, 6'd0, 8);
        check("sat_clr_b", sat_flag, 0);
        for (int b = 0; b < 5; b++) run_block(0, -32768, 0, -32768, 1'b0);
        idle(8);
        check("sat_neg_lane1", sat_flag, 2'b10);

        // R above MAX_DECIM clamps to 64, shift 63 clamps to 33 (no guard-bit overflow).
        do_cfg(7'd72, 6'd63, 64);
        for (int b = 0; b < 5; b++) run_block(32767, -32768, 1, -1, 1'b0);
        idle(8);
        check("clamp_sat", sat_flag, 0);

        // rst mid-burst discards a pending result.
        out_ready = 1'b0;
        run_block(32767, -32768, 1, -1, 1'b0);
        idle(6);
        in_valid = 1'b1;
        in_data  = pk(7, 7);
        idle(3);
        do_reset(7'd8, 6'd9, 8);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_overrun", overrun, 0);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) run_block(100, -100, 100, -100, 1'b0);
        idle(10);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
